ws2812_decoder: RTL and testbench
=================================

# ws2812_decoder

Consumes the edge flags and pulse-width count from the edge-detect and counter stages of the WS2812 receive pipeline. Classifies each high pulse as a 0 or 1 bit and assembles 24-bit GRB pixels, MSB first. Detects the line-low latch (frame reset). Hands pixels downstream over a valid/ready interface with a one-entry holding register.

## Interface
Counter tick is 100 ns. The counter saturates at 512 ticks (51.2 µs).

Parameters:
- BIT_THRESHOLD, 6: high width in ticks; width >= threshold decodes as 1, otherwise 0 (T0H ≈ 4, T1H ≈ 8).
- MIN_HIGH, 2: high width below this is a glitch error.
- MAX_HIGH, 16: high width above this is a stuck-high error.

Ports:
- i_clk, in, 1: clock; single clock domain.
- i_reset, in, 1: synchronous, active-high reset.
- i_control, in, control_path_t: rising/falling edge flags, one-cycle pulses.
- i_decoder_input, in, decoder_input_t: .counter, 10 bits; holds the high width in the cycle falling is asserted.
- o_pixel, out, pixel_t (24): {g,r,b}, valid while o_pixel_valid.
- o_pixel_valid, out, 1: holding register full.
- i_pixel_ready, in, 1: downstream accepts when valid && ready.
- o_pixel_index, out, 8: index of o_pixel within its frame.
- o_frame_reset, out, 1: one-cycle pulse per detected latch.
- o_error, out, 1: one-cycle pulse on a width or partial-pixel error.
- o_overflow, out, 1: one-cycle pulse when a completed pixel is dropped.

## Operation
- Line level is tracked internally: rising sets it to 1, falling sets it to 0. Reset value is 0.
- **Latch detect:**
  - Condition: level == 0, counter[9] == 1, and the latch has not already been seen for this low period.
  - The latch flag clears on rising.
- **FSM states:**
  - S_SYNC: the reset state. Pulses are ignored. A latch moves to S_DATA with bit_cnt = 0 and pixel index 0.
  - S_DATA, on falling: width = counter.
    - width < MIN_HIGH or width > MAX_HIGH (including a saturated counter): o_error, discard shift register, go to S_SYNC.
    - Otherwise: shift in (width >= BIT_THRESHOLD), bit_cnt++.
  - S_DATA, 24th bit: load the holding register, bit_cnt = 0.
  - S_DATA, latch:
    - o_frame_reset pulses.
    - If bit_cnt != 0, o_error also pulses and the partial pixel is discarded.
    - bit_cnt = 0, index = 0, stay in S_DATA.
- o_frame_reset also pulses on the S_SYNC→S_DATA latch.
- **Pixel index:**
  - Increments on each completed pixel, including dropped ones.
  - Wraps 255→0.
  - o_pixel_index is captured together with o_pixel.
- **Holding register:**
  - Empty, or accept in the same cycle: the new pixel loads and valid stays or becomes 1.
  - Full and not ready: the new pixel is dropped, o_overflow pulses, and the old pixel is retained.
  - Pixel and valid are stable until accepted.
- A frame reset does not flush a held pixel.

## Timing
- **Reset values:** o_pixel = 0, o_pixel_valid = 0, o_pixel_index = 0, o_frame_reset = 0, o_error = 0, o_overflow = 0, state = S_SYNC, bit_cnt = 0.
- **Reset mid-operation:** discards the partial pixel and the held pixel.
- **Latency:**
  - Falling edge of bit 24 in cycle N: o_pixel_valid = 1 in cycle N+1.
  - Latch condition first true in cycle N: o_frame_reset in cycle N+1.
  - Error pulses in the cycle after the offending event.
- Rising and falling flags never coincide. If they do, falling has priority and rising is ignored.
- Falling and latch in the same cycle cannot occur (level high); no special handling.
- Width checks are unsigned 10-bit compares against the parameters.

## Structure
- pipeline_types gains:
  - pixel_t: packed struct {g, r, b}, 8 bits each.
  - decoder_state_e: S_SYNC, S_DATA.
  - Default threshold constants.
- Sub-module pixel_holding_reg: one-entry valid/ready register with overflow pulse.
- The FSM, shift register and latch detect live in the top.

## Test plan
- After reset, no latch, 24 pulses of width 8 → no o_pixel_valid, no errors (S_SYNC).
- Latch (counter reaches 512, level low), then 24 pulses alternating widths 8/4 starting with 8, i_pixel_ready = 1:
  - o_frame_reset pulses once.
  - o_pixel = 0xAAAAAA, index 0, valid one cycle after the 24th falling edge.
- Two pixels with i_pixel_ready = 0, then a third pixel:
  - First pixel is held.
  - Second and third each give o_overflow, index 1 and 2 consumed.
  - Ready = 1 then accepts the first pixel unchanged.
- In S_DATA, a pulse of width 1, and separately one of width 20 → o_error, return to S_SYNC, later pulses ignored until the next latch.
- 10 bits, then a latch → o_error and o_frame_reset in the same cycle. The next 24 bits yield pixel index 0.
- i_reset asserted at bit 12 with a held pixel → all outputs 0 the next cycle, state S_SYNC.

Source files
------------

// File: rtl/ws2812_decoder_pkg.sv
// rtl/ws2812_decoder_pkg.sv - shared types and default thresholds for the WS2812 receive pipeline
package ws2812_decoder_pkg;

  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;

  typedef struct packed {
    logic [9:0] counter;
  } decoder_input_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    S_SYNC,
    S_DATA
  } decoder_state_e;

  localparam int unsigned PIXEL_BITS            = 24;
  localparam int unsigned DEFAULT_BIT_THRESHOLD = 6;
  localparam int unsigned DEFAULT_MIN_HIGH      = 2;
  localparam int unsigned DEFAULT_MAX_HIGH      = 16;

endpackage

// File: rtl/ws2812_decoder_holding_reg.sv
// rtl/ws2812_decoder_holding_reg.sv - one-entry valid/ready pixel register with overflow pulse
module pixel_holding_reg
  import ws2812_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  pixel_t     i_pixel,
  input  logic [7:0] i_index,
  input  logic       i_pixel_ready,
  output pixel_t     o_pixel,
  output logic       o_pixel_valid,
  output logic [7:0] o_pixel_index,
  output logic       o_overflow
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_index <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      if (i_load) begin
        // A full register that is not being drained keeps its pixel; the newcomer is lost.
        if (!o_pixel_valid || i_pixel_ready) begin
          o_pixel       <= i_pixel;
          o_pixel_index <= i_index;
          o_pixel_valid <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
      end else if (o_pixel_valid && i_pixel_ready) begin
        o_pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812_decoder.sv
// rtl/ws2812_decoder.sv - classifies WS2812 high pulses into bits, assembles GRB pixels, detects latch
module ws2812_decoder
  import ws2812_decoder_pkg::*;
#(
  parameter int unsigned BIT_THRESHOLD = DEFAULT_BIT_THRESHOLD,
  parameter int unsigned MIN_HIGH      = DEFAULT_MIN_HIGH,
  parameter int unsigned MAX_HIGH      = DEFAULT_MAX_HIGH
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  control_path_t  i_control,
  input  decoder_input_t i_decoder_input,
  output pixel_t         o_pixel,
  output logic           o_pixel_valid,
  input  logic           i_pixel_ready,
  output logic [7:0]     o_pixel_index,
  output logic           o_frame_reset,
  output logic           o_error,
  output logic           o_overflow
);

  localparam logic [9:0] THR_W = 10'(BIT_THRESHOLD);
  localparam logic [9:0] MIN_W = 10'(MIN_HIGH);
  localparam logic [9:0] MAX_W = 10'(MAX_HIGH);
  localparam logic [4:0] LAST_BIT = 5'(PIXEL_BITS - 1);

  decoder_state_e state_q, state_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [22:0]    shift_q, shift_d;
  logic [7:0]     index_q, index_d;
  logic           frame_reset_d, error_d;
  logic           level_q, latch_seen_q;
  logic [9:0]     width;
  logic           latch, bit_val, width_bad, load;
  pixel_t         load_pixel;

  assign width     = i_decoder_input.counter;
  assign latch     = !level_q && width[9] && !latch_seen_q;
  assign bit_val   = (width >= THR_W);
  assign width_bad = (width < MIN_W) || (width > MAX_W);

  // Falling wins if both edges are flagged; the latch flag re-arms only on a genuine rise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q      <= 1'b0;
      latch_seen_q <= 1'b0;
    end else begin
      if (i_control.falling)      level_q <= 1'b0;
      else if (i_control.rising)  level_q <= 1'b1;
      if (i_control.rising && !i_control.falling) latch_seen_q <= 1'b0;
      else if (latch)                             latch_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_SYNC;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      index_q       <= '0;
      o_frame_reset <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      index_q       <= index_d;
      o_frame_reset <= frame_reset_d;
      o_error       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    index_d       = index_q;
    frame_reset_d = 1'b0;
    error_d       = 1'b0;
    load          = 1'b0;
    load_pixel    = pixel_t'({shift_q, bit_val});
    case (state_q)
      S_SYNC: begin
        if (latch) begin
          state_d       = S_DATA;
          bit_cnt_d     = '0;
          index_d       = '0;
          shift_d       = '0;
          frame_reset_d = 1'b1;
        end
      end
      S_DATA: begin
        if (i_control.falling) begin
          if (width_bad) begin
            error_d   = 1'b1;
            state_d   = S_SYNC;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            shift_d = {shift_q[21:0], bit_val};
            if (bit_cnt_q == LAST_BIT) begin
              load      = 1'b1;
              bit_cnt_d = '0;
              index_d   = index_q + 8'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (latch) begin
          frame_reset_d = 1'b1;
          error_d       = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          index_d       = '0;
          shift_d       = '0;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  pixel_holding_reg u_hold (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load        (load),
    .i_pixel       (load_pixel),
    .i_index       (index_q),
    .i_pixel_ready (i_pixel_ready),
    .o_pixel       (o_pixel),
    .o_pixel_valid (o_pixel_valid),
    .o_pixel_index (o_pixel_index),
    .o_overflow    (o_overflow)
  );

endmodule

// File: tb/tb_ws2812_decoder.sv
// tb/tb_ws2812_decoder.sv - scoreboard bench for ws2812_decoder
module tb_ws2812_decoder;
  import ws2812_decoder_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  control_path_t  ctl;
  decoder_input_t din;
  pixel_t         pix;
  logic           pv, ready;
  logic [7:0]     pidx;
  logic           fr, er, ov;

  always #5 clk = ~clk;

  ws2812_decoder dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_control       (ctl),
    .i_decoder_input (din),
    .o_pixel         (pix),
    .o_pixel_valid   (pv),
    .i_pixel_ready   (ready),
    .o_pixel_index   (pidx),
    .o_frame_reset   (fr),
    .o_error         (er),
    .o_overflow      (ov)
  );

  int errors = 0;
  int checks = 0;
  int n_frame = 0, n_err = 0, n_ovf = 0, n_coinc = 0, n_pix = 0;
  logic [31:0] exp_q[$];
  logic last_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, pops the scoreboard on every handshake.
  initial begin
    logic        held;
    logic [31:0] held_v;
    logic [31:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (fr) n_frame++;
        if (er) n_err++;
        if (ov) n_ovf++;
        if (fr && er) n_coinc++;
        if (held && pv) check("held_stable", {pidx, pix}, held_v);
        if (pv && ready) begin
          n_pix++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %0h expected none", {pidx, pix});
          end else begin
            e = exp_q.pop_front();
            check("pixel", {pidx, pix}, e);
          end
          held = 1'b0;
        end else if (pv) begin
          held   = 1'b1;
          held_v = {pidx, pix};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic send_bit(input int w);
    ctl.rising = 1'b1; din.counter = 10'd0;
    @(posedge clk); #2;
    ctl.rising = 1'b0; din.counter = 10'd1;
    @(posedge clk); #2;
    ctl.falling = 1'b1; din.counter = 10'(w);
    @(posedge clk); #1;
    last_valid = pv;
    #1;
    ctl.falling = 1'b0; din.counter = 10'd3;
    @(posedge clk); #2;
  endtask

  task automatic send_pixel(input logic [23:0] px, input int w1, input int w0, input bit chk);
    for (int i = 23; i >= 0; i--) begin
      send_bit(px[i] ? w1 : w0);
      if (chk && i == 1) check("valid_before_24th", {31'd0, last_valid}, 32'd0);
      if (chk && i == 0) check("valid_after_24th", {31'd0, last_valid}, 32'd1);
    end
  endtask

  task automatic send_latch(output logic f1, output logic f2);
    din.counter = 10'h200;
    @(posedge clk); #1; f1 = fr; #1;
    @(posedge clk); #1; f2 = fr; #1;
    repeat (2) begin @(posedge clk); #2; end
    din.counter = 10'd3;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f1, f2;
    rst = 1'b1; ctl = '0; din = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", 32'(pix), 32'd0);
    check("rst_valid", {31'd0, pv}, 32'd0);
    check("rst_index", {24'd0, pidx}, 32'd0);
    check("rst_frame", {31'd0, fr}, 32'd0);
    check("rst_error", {31'd0, er}, 32'd0);
    check("rst_ovf",   {31'd0, ov}, 32'd0);
    #1; rst = 1'b0;
    idle(2);

    // Unsynchronised: pulses ignored
    send_pixel(24'hFFFFFF, 8, 4, 1'b0);
    idle(2);
    check("sync_pix", n_pix, 0);
    check("sync_err", n_err, 0);
    check("sync_frame", n_frame, 0);

    // First frame
    send_latch(f1, f2);
    check("latch_pulse_n1", {31'd0, f1}, 32'd1);
    check("latch_pulse_n2", {31'd0, f2}, 32'd0);
    exp_q.push_back({8'd0, 24'hAAAAAA});
    send_pixel(24'hAAAAAA, 8, 4, 1'b1);
    idle(2);
    check("f1_frame", n_frame, 1);
    check("f1_err", n_err, 0);
    check("f1_pix", n_pix, 1);

    // Backpressure and overflow
    send_latch(f1, f2);
    ready = 1'b0;
    exp_q.push_back({8'd0, 24'h123456});
    send_pixel(24'h123456, 8, 4, 1'b0);
    send_pixel(24'hFFFFFF, 8, 4, 1'b0);
    send_pixel(24'h0F0F0F, 8, 4, 1'b0);
    idle(2);
    check("ovf_count", n_ovf, 2);
    check("ovf_pix", n_pix, 1);
    ready = 1'b1;
    idle(2);
    check("ovf_drain", n_pix, 2);
    exp_q.push_back({8'd3, 24'hC3C3C3});
    send_pixel(24'hC3C3C3, 8, 4, 1'b0);
    idle(2);
    check("idx3_pix", n_pix, 3);

    // Width errors
    for (int i = 0; i < 5; i++) send_bit(8);
    send_bit(1);
    idle(2);
    check("glitch_err", n_err, 1);
    send_pixel(24'hFFFFFF, 8, 4, 1'b0);
    idle(2);
    check("glitch_ignored", n_pix, 3);
    send_latch(f1, f2);
    check("relatch_noerr", n_err, 1);
    for (int i = 0; i < 3; i++) send_bit(4);
    send_bit(20);
    idle(2);
    check("stuck_err", n_err, 2);
    send_latch(f1, f2);
    exp_q.push_back({8'd0, 24'h5A5A5A});
    send_pixel(24'h5A5A5A, 6, 5, 1'b0);
    exp_q.push_back({8'd1, 24'h3CC3A5});
    send_pixel(24'h3CC3A5, 16, 2, 1'b0);
    idle(2);
    check("bound_err", n_err, 2);
    check("bound_pix", n_pix, 5);

    // Partial pixel at latch
    for (int i = 0; i < 10; i++) send_bit(8);
    send_latch(f1, f2);
    idle(1);
    check("partial_coinc", n_coinc, 1);
    check("partial_err", n_err, 3);
    exp_q.push_back({8'd0, 24'h5A3C0F});
    send_pixel(24'h5A3C0F, 8, 4, 1'b0);
    idle(2);
    check("frame_total", n_frame, 5);
    check("partial_pix", n_pix, 6);

    // Reset mid-pixel with a held pixel
    ready = 1'b0;
    send_pixel(24'h777777, 8, 4, 1'b0);
    for (int i = 0; i < 12; i++) send_bit(8);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_valid", {31'd0, pv}, 32'd0);
    check("mrst_pixel", 32'(pix), 32'd0);
    check("mrst_index", {24'd0, pidx}, 32'd0);
    check("mrst_pulses", {29'd0, fr, er, ov}, 32'd0);
    #1; rst = 1'b0; ready = 1'b1;
    idle(2);
    send_pixel(24'hFFFFFF, 8, 4, 1'b0);
    idle(2);
    check("mrst_sync", n_pix, 6);
    send_latch(f1, f2);
    exp_q.push_back({8'd0, 24'h0F1E2D});
    send_pixel(24'h0F1E2D, 8, 4, 1'b0);
    idle(3);
    check("final_pix", n_pix, 7);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
